// File: rtl/alu181_serial.sv
// alu181_serial: slice-serial 74181-style ALU.
// One SLICE_W-bit slice of the 74181 function is evaluated per cycle, LSB
// slice first, with the ripple carry held in a register between slices.
// Operands are latched on an accepted start and shifted right one slice per
// cycle, so the active slice always sits in the low bits. Results and flags
// are loaded only on the done edge and are held until the next done.
module alu181_serial #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout_n,
  output logic             ovf,
  output logic             eqv
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned TOP_SH = WIDTH - SLICE_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_s;
  logic               r_m;
  logic               r_carry;
  logic [WIDTH-1:0]   r_acc;

  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_x;
  logic [SLICE_W-1:0] w_y;
  logic [SLICE_W:0]   w_sum;
  logic [SLICE_W-1:0] w_res;
  logic               w_cout;
  logic               w_cmsb;
  logic               w_last;
  logic [WIDTH-1:0]   w_acc_next;

  // One 74181 slice: generate/propagate-style X/Y terms, then add or XNOR
  always_comb begin
    w_a_sl = r_a[SLICE_W-1:0];
    w_b_sl = r_b[SLICE_W-1:0];
    w_x    = w_a_sl
           | (w_b_sl  & {SLICE_W{r_s[0]}})
           | (~w_b_sl & {SLICE_W{r_s[1]}});
    w_y    = (w_a_sl & ~w_b_sl & {SLICE_W{r_s[2]}})
           | (w_a_sl &  w_b_sl & {SLICE_W{r_s[3]}});
    w_sum  = {1'b0, w_x} + {1'b0, w_y} + (SLICE_W + 1)'(r_carry);
    w_cout = w_sum[SLICE_W];
    // carry into the slice MSB recovered from the MSB sum bit
    w_cmsb = w_sum[SLICE_W-1] ^ w_x[SLICE_W-1] ^ w_y[SLICE_W-1];
    w_res  = r_m ? ~(w_x ^ w_y) : w_sum[SLICE_W-1:0];
  end

  // Accumulator fills from the top so slice 0 ends up at the LSB
  always_comb begin
    w_acc_next = (r_acc >> SLICE_W) | (WIDTH'(w_res) << TOP_SH);
    w_last     = (r_idx == IDX_W'(NSLICE - 1));
  end

  // Sequencer: accept in IDLE, one slice per cycle in RUN, publish on last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f       <= '0;
      cout_n  <= 1'b1;
      ovf     <= 1'b0;
      eqv     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_s     <= s;
            r_m     <= m;
            r_carry <= ~cin_n;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            f       <= w_acc_next;
            cout_n  <= r_m ? 1'b1 : ~w_cout;
            ovf     <= r_m ? 1'b0 : (w_cmsb ^ w_cout);
            eqv     <= &w_acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_idx   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu181_serial.sv
// Bench for alu181_serial: a full-width arithmetic model of the 74181
// function set predicts each result; a per-cycle compare process checks
// busy/done timing, results on done and that outputs hold between dones.
module tb_alu181_serial;

  localparam int NS16 = 4;

  typedef struct {
    logic [31:0] f;
    logic        co_n;
    logic        ov;
    logic        eq;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic        m, cin_n;
  logic        busy, done, cout_n, ovf, eqv;
  logic [15:0] f;

  logic        start8;
  logic [7:0]  a8, b8;
  logic [3:0]  s8;
  logic        m8, cin8;
  logic        busy8, done8, cout8, ovf8, eqv8;
  logic [7:0]  f8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t hold;

  alu181_serial #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .s(s), .m(m),
    .cin_n(cin_n), .busy(busy), .done(done), .f(f), .cout_n(cout_n),
    .ovf(ovf), .eqv(eqv)
  );

  alu181_serial #(.WIDTH(8), .SLICE_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .s(s8), .m(m8),
    .cin_n(cin8), .busy(busy8), .done(done8), .f(f8), .cout_n(cout8),
    .ovf(ovf8), .eqv(eqv8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-word 74181 arithmetic on a w-bit operand pair
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [3:0] sv, input logic mv, input logic cn);
    exp_t r;
    longint unsigned mask, lmask, aa, bb, nb, x, y, sum, low, ci, co, cm;
    mask  = (64'd1 << w) - 64'd1;
    lmask = (64'd1 << (w - 1)) - 64'd1;
    aa = 64'(av) & mask;
    bb = 64'(bv) & mask;
    nb = ~bb & mask;
    x  = aa | (sv[0] ? bb : 64'd0) | (sv[1] ? nb : 64'd0);
    y  = (sv[2] ? (aa & nb) : 64'd0) | (sv[3] ? (aa & bb) : 64'd0);
    ci = cn ? 64'd0 : 64'd1;
    if (mv) begin
      r.f    = 32'(~(x ^ y) & mask);
      r.co_n = 1'b1;
      r.ov   = 1'b0;
    end else begin
      sum    = x + y + ci;
      low    = (x & lmask) + (y & lmask) + ci;
      co     = (sum >> w) & 64'd1;
      cm     = (low >> (w - 1)) & 64'd1;
      r.f    = 32'(sum & mask);
      r.co_n = (co == 64'd0);
      r.ov   = (co != cm);
    end
    r.eq  = (64'(r.f) == mask);
    r.due = 0;
    return r;
  endfunction

  // Per-cycle check of the 16-bit instance against the pending queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() != 0 && cyc == q[0].due) begin
        chk("done", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        hold = q.pop_front();
        chk("f", 32'(f), hold.f);
        chk("cout_n", 32'(cout_n), 32'(hold.co_n));
        chk("ovf", 32'(ovf), 32'(hold.ov));
        chk("eqv", 32'(eqv), 32'(hold.eq));
      end else begin
        chk("done_idle", 32'(done), 32'd0);
        chk("busy", 32'(busy), 32'((q.size() != 0) && (cyc < q[0].due)));
        chk("f_hold", 32'(f), hold.f);
        chk("flags_hold", {29'd0, cout_n, ovf, eqv}, {29'd0, hold.co_n, hold.ov, hold.eq});
      end
    end
  end

  // Drive one request (caller guarantees the DUT is idle)
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] is_,
                       input logic im, input logic icn);
    exp_t e;
    a = ia; b = ib; s = is_; m = im; cin_n = icn; start = 1'b1;
    e = model(16, 32'(ia), 32'(ib), is_, im, icn);
    e.due = cyc + 1 + NS16;
    q.push_back(e);
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk); #2;
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic pin(input string name, input exp_t r, input logic [31:0] ef,
                     input logic eco, input logic eov, input logic eeq);
    chk({name, "_f"}, r.f, ef);
    chk({name, "_flags"}, {29'd0, r.co_n, r.ov, r.eq}, {29'd0, eco, eov, eeq});
  endtask

  initial begin
    exp_t r;
    int   k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin_n = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; s8 = '0; m8 = 1'b0; cin8 = 1'b1;
    hold.f = 32'd0; hold.co_n = 1'b1; hold.ov = 1'b0; hold.eq = 1'b0; hold.due = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_flags", {29'd0, cout_n, ovf, eqv}, 32'b100);
    rst_n = 1'b1;

    // Pin the model to hand-computed values
    pin("m_or_inc", model(16, 32'h0002, 32'h000A, 4'b0001, 1'b0, 1'b0), 32'h000B, 1'b1, 1'b0, 1'b0);
    pin("m_cmp_eq", model(16, 32'h1234, 32'h1234, 4'b0110, 1'b0, 1'b1), 32'hFFFF, 1'b1, 1'b0, 1'b1);
    pin("m_sub",    model(16, 32'h1234, 32'h0034, 4'b0110, 1'b0, 1'b0), 32'h1200, 1'b0, 1'b0, 1'b0);
    pin("m_ripple", model(16, 32'hFFFF, 32'h0000, 4'b1001, 1'b0, 1'b0), 32'h0000, 1'b0, 1'b0, 1'b0);
    pin("m_ovf",    model(16, 32'h7FFF, 32'h0001, 4'b1001, 1'b0, 1'b1), 32'h8000, 1'b1, 1'b1, 1'b0);
    pin("m_xor",    model(16, 32'h00F0, 32'h0FF0, 4'b0110, 1'b1, 1'b0), 32'h0F00, 1'b1, 1'b0, 1'b0);
    pin("m_and",    model(16, 32'h00F0, 32'h0FF0, 4'b1011, 1'b1, 1'b1), 32'h00F0, 1'b1, 1'b0, 1'b0);
    pin("m_dec",    model(16, 32'h5555, 32'h1234, 4'b0011, 1'b0, 1'b1), 32'hFFFF, 1'b1, 1'b0, 1'b1);
    pin("m_w8",     model(8,  32'h80,   32'h80,   4'b1001, 1'b0, 1'b1), 32'h00,   1'b0, 1'b1, 1'b0);

    // Directed vectors, issued back-to-back at the first legal edge
    issue(16'h0002, 16'h000A, 4'b0001, 1'b0, 1'b0); wait_idle();
    issue(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1); wait_idle();
    issue(16'h1234, 16'h0034, 4'b0110, 1'b0, 1'b0); wait_idle();
    issue(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b0); wait_idle();
    issue(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1); wait_idle();
    issue(16'h00F0, 16'h0FF0, 4'b0110, 1'b1, 1'b0); wait_idle();
    issue(16'h00F0, 16'h0FF0, 4'b0110, 1'b1, 1'b1); wait_idle();
    repeat (3) begin @(negedge clk); #2; end

    // Start pulses and operand churn while busy must be ignored
    issue(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); cin_n = 1'($urandom);
      @(negedge clk); #2;
    end
    start = 1'b0;
    wait_idle();

    // Full function sweep in both modes
    for (int mm = 0; mm < 2; mm++) begin
      for (int ss = 0; ss < 16; ss++) begin
        issue(16'hA5C3 + 16'(ss * 16'h1357), 16'h3C96 ^ 16'(ss * 16'h0F0F), 4'(ss), 1'(mm), 1'(ss & 1));
        wait_idle();
      end
    end
    issue(16'h00FF, 16'h0F00, 4'b1110, 1'b1, 1'b0); wait_idle();
    chk("pre_rst_f_nonzero", 32'(f != 16'h0000), 32'd1);

    // Reset during slice 2 aborts the operation
    issue(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
    repeat (2) begin @(negedge clk); #2; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_f", 32'(f), 32'd0);
    chk("abort_flags", {29'd0, cout_n, ovf, eqv}, 32'b100);
    q.delete();
    hold.f = 32'd0; hold.co_n = 1'b1; hold.ov = 1'b0; hold.eq = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); #2; end
    issue(16'h0102, 16'h0304, 4'b1001, 1'b0, 1'b1); wait_idle();

    // Narrow instance: WIDTH=8, SLICE_W=2
    a8 = 8'h80; b8 = 8'h80; s8 = 4'b1001; m8 = 1'b0; cin8 = 1'b1; start8 = 1'b1;
    k = cyc + 1;
    @(negedge clk); #2;
    start8 = 1'b0;
    for (int i = 0; i < 10 && !done8; i++) @(negedge clk);
    r = model(8, 32'h80, 32'h80, 4'b1001, 1'b0, 1'b1);
    chk("w8_done", 32'(done8), 32'd1);
    chk("w8_latency", 32'(cyc - k), 32'd4);
    chk("w8_f", 32'(f8), r.f);
    chk("w8_flags", {29'd0, cout8, ovf8, eqv8}, {29'd0, r.co_n, r.ov, r.eq});
    chk("w8_busy", 32'(busy8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
